// File: rtl/pipe_pkg.sv
// Shared pipeline types: decoded control bundle, bubble constant, opcode constants
// used by both the decoder and the ID/EX stage.
package pipe_pkg;

  typedef struct packed {
    logic rs2_imm_sel;
    logic reg_w_en;
    logic mem_w_en;
    logic mem_alu_sel;
    logic branch_detect;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // A load is a writing instruction whose writeback comes from memory.
  function automatic logic is_load(input logic valid, input ctrl_t c);
    return valid & c.reg_w_en & ~c.mem_alu_sel;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the instruction in ID and a load in EX.
// A taken-branch flush suppresses the stall so IF/ID can accept the redirect.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int RIDX_W = 5
) (
  input  logic              id_valid,
  input  logic [RIDX_W-1:0] id_rs1_idx,
  input  logic [RIDX_W-1:0] id_rs2_idx,
  input  logic              id_rs2_imm_sel,
  input  logic              id_mem_w_en,
  input  logic              ex_valid,
  input  ctrl_t             ex_ctrl,
  input  logic [RIDX_W-1:0] ex_rd_idx,
  input  logic              ex_flush,
  output logic              stall
);

  logic load_in_ex;
  logic rs1_use;
  logic rs2_use;
  logic rs1_hit;
  logic rs2_hit;

  assign load_in_ex = is_load(ex_valid, ex_ctrl);
  assign rs1_use    = (id_rs1_idx != '0);
  // rs2 is read by R-type and branches, and by stores as the store data.
  assign rs2_use    = (~id_rs2_imm_sel | id_mem_w_en) & (id_rs2_idx != '0);
  assign rs1_hit    = rs1_use & (ex_rd_idx == id_rs1_idx);
  assign rs2_hit    = rs2_use & (ex_rd_idx == id_rs2_idx);
  assign stall      = id_valid & load_in_ex & (rs1_hit | rs2_hit) & ~ex_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush bubble insertion.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [RIDX_W-1:0] id_rs1_idx,
  input  logic [RIDX_W-1:0] id_rs2_idx,
  input  logic [RIDX_W-1:0] id_rd_idx,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_rs2_imm_sel,
  input  logic              id_reg_w_en,
  input  logic              id_mem_w_en,
  input  logic              id_mem_alu_sel,
  input  logic              id_branch_detect,
  input  logic              ex_flush,
  output logic              stall_o,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [RIDX_W-1:0] ex_rs1_idx,
  output logic [RIDX_W-1:0] ex_rs2_idx,
  output logic [RIDX_W-1:0] ex_rd_idx,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic              ex_rs2_imm_sel,
  output logic              ex_reg_w_en,
  output logic              ex_mem_w_en,
  output logic              ex_mem_alu_sel,
  output logic              ex_branch_detect
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl_reg;
  logic  stall;

  assign id_ctrl = '{rs2_imm_sel:   id_rs2_imm_sel,
                     reg_w_en:      id_reg_w_en,
                     mem_w_en:      id_mem_w_en,
                     mem_alu_sel:   id_mem_alu_sel,
                     branch_detect: id_branch_detect};

  load_use_detect #(.RIDX_W(RIDX_W)) u_hazard (
    .id_valid       (id_valid),
    .id_rs1_idx     (id_rs1_idx),
    .id_rs2_idx     (id_rs2_idx),
    .id_rs2_imm_sel (id_rs2_imm_sel),
    .id_mem_w_en    (id_mem_w_en),
    .ex_valid       (ex_valid),
    .ex_ctrl        (ex_ctrl_reg),
    .ex_rd_idx      (ex_rd_idx),
    .ex_flush       (ex_flush),
    .stall          (stall)
  );

  assign stall_o = stall;

  // Data fields load every cycle; only valid and controls define a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_ctrl_reg <= CTRL_BUBBLE;
      ex_pc       <= '0;
      ex_rs1_idx  <= '0;
      ex_rs2_idx  <= '0;
      ex_rd_idx   <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
    end else begin
      ex_pc       <= id_pc;
      ex_rs1_idx  <= id_rs1_idx;
      ex_rs2_idx  <= id_rs2_idx;
      ex_rd_idx   <= id_rd_idx;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      if (ex_flush || stall) begin
        ex_valid    <= 1'b0;
        ex_ctrl_reg <= CTRL_BUBBLE;
      end else begin
        ex_valid    <= id_valid;
        ex_ctrl_reg <= id_valid ? id_ctrl : CTRL_BUBBLE;
      end
    end
  end

  assign ex_rs2_imm_sel   = ex_ctrl_reg.rs2_imm_sel;
  assign ex_reg_w_en      = ex_ctrl_reg.reg_w_en;
  assign ex_mem_w_en      = ex_ctrl_reg.mem_w_en;
  assign ex_mem_alu_sel   = ex_ctrl_reg.mem_alu_sel;
  assign ex_branch_detect = ex_ctrl_reg.branch_detect;

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (ex_flush && id_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, pass-through, load-use stall,
// non-stalling cases, store-data hazard, invalid capture and flush priority.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1_idx, id_rs2_idx, id_rd_idx;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_rs2_imm_sel, id_reg_w_en, id_mem_w_en, id_mem_alu_sel, id_branch_detect;
  logic        ex_flush;
  logic        stall_o;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1_idx, ex_rs2_idx, ex_rd_idx;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic        ex_rs2_imm_sel, ex_reg_w_en, ex_mem_w_en, ex_mem_alu_sel, ex_branch_detect;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // control vectors {rs2_imm_sel, reg_w_en, mem_w_en, mem_alu_sel, branch_detect}
  localparam logic [4:0] C_RTYPE = 5'b01010;
  localparam logic [4:0] C_ITYPE = 5'b11010;
  localparam logic [4:0] C_LOAD  = 5'b11000;
  localparam logic [4:0] C_STORE = 5'b10100;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx), .id_rd_idx(id_rd_idx),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs2_imm_sel(id_rs2_imm_sel), .id_reg_w_en(id_reg_w_en), .id_mem_w_en(id_mem_w_en),
    .id_mem_alu_sel(id_mem_alu_sel), .id_branch_detect(id_branch_detect),
    .ex_flush(ex_flush), .stall_o(stall_o), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_idx(ex_rs1_idx), .ex_rs2_idx(ex_rs2_idx), .ex_rd_idx(ex_rd_idx),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs2_imm_sel(ex_rs2_imm_sel), .ex_reg_w_en(ex_reg_w_en), .ex_mem_w_en(ex_mem_w_en),
    .ex_mem_alu_sel(ex_mem_alu_sel), .ex_branch_detect(ex_branch_detect)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  // Drive one ID instruction at the falling edge; data fields derive from pc.
  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [4:0] c);
    @(negedge clk);
    id_valid = v; id_pc = pc; id_rs1_idx = rs1; id_rs2_idx = rs2; id_rd_idx = rd;
    id_rs1_data = pc + 32'd1; id_rs2_data = pc + 32'd2; id_imm = pc + 32'd3;
    {id_rs2_imm_sel, id_reg_w_en, id_mem_w_en, id_mem_alu_sel, id_branch_detect} = c;
    #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_flush = 1'b0;
    set_id(1'b1, 32'h80, 5'd1, 5'd2, 5'd3, C_RTYPE);
    step(); step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", ex_valid); end
    checks++; if (ex_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", ex_pc); end
    checks++; if ({ex_rs2_imm_sel, ex_reg_w_en, ex_mem_w_en, ex_mem_alu_sel, ex_branch_detect} !== 5'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b expected 00000",
        {ex_rs2_imm_sel, ex_reg_w_en, ex_mem_w_en, ex_mem_alu_sel, ex_branch_detect}); end
    checks++; if (ex_rd_idx !== 5'd0 || ex_imm !== 32'h0) begin errors++;
      $display("FAIL reset_data: got rd=%0d imm=%h expected 0", ex_rd_idx, ex_imm); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall_o); end
    $display("reset: ex_valid=%0b stall_o=%0b", ex_valid, stall_o);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    set_id(1'b1, 32'h100, 5'd3, 5'd4, 5'd5, C_RTYPE);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL pass_stall_pre: got %0b expected 0", stall_o); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_rd_idx !== 5'd5) begin errors++;
      $display("FAIL pass_fields: got v=%0b pc=%h rd=%0d expected v=1 pc=00000100 rd=5", ex_valid, ex_pc, ex_rd_idx); end
    checks++; if ({ex_rs2_imm_sel, ex_reg_w_en, ex_mem_w_en, ex_mem_alu_sel, ex_branch_detect} !== C_RTYPE)
      begin errors++; $display("FAIL pass_ctrl: got %b expected %b",
        {ex_rs2_imm_sel, ex_reg_w_en, ex_mem_w_en, ex_mem_alu_sel, ex_branch_detect}, C_RTYPE); end
    checks++; if (ex_rs1_data !== 32'h101 || ex_rs2_data !== 32'h102 || ex_imm !== 32'h103) begin errors++;
      $display("FAIL pass_data: got %h %h %h expected 00000101 00000102 00000103", ex_rs1_data, ex_rs2_data, ex_imm); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL pass_stall_post: got %0b expected 0", stall_o); end
    $display("pass_through: ex_pc=%h ex_valid=%0b stall_o=%0b", ex_pc, ex_valid, stall_o);
  endtask

  task automatic test_load_use();
    int stall_cycles = 0;
    set_id(1'b1, 32'h200, 5'd2, 5'd0, 5'd5, C_LOAD);      // lw x5,0(x2)
    step();
    set_id(1'b1, 32'h204, 5'd5, 5'd7, 5'd6, C_RTYPE);     // add x6,x5,x7
    if (stall_o === 1'b1) stall_cycles++;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b expected 1", stall_o); end
    step();
    checks++; if (ex_valid !== 1'b0 || ex_reg_w_en !== 1'b0 || ex_mem_alu_sel !== 1'b0) begin errors++;
      $display("FAIL lu_bubble: got v=%0b rw=%0b mas=%0b expected 0 0 0", ex_valid, ex_reg_w_en, ex_mem_alu_sel); end
    if (stall_o === 1'b1) stall_cycles++;
    step();
    checks++; if (stall_cycles != 1) begin errors++; $display("FAIL lu_stall_len: got %0d expected 1", stall_cycles); end
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h204 || ex_rd_idx !== 5'd6) begin errors++;
      $display("FAIL lu_add_in_ex: got v=%0b pc=%h rd=%0d expected v=1 pc=00000204 rd=6", ex_valid, ex_pc, ex_rd_idx); end
    $display("load_use: stall_cycles=%0d ex_pc=%h", stall_cycles, ex_pc);
  endtask

  task automatic test_no_stall();
    set_id(1'b1, 32'h300, 5'd2, 5'd0, 5'd0, C_LOAD);      // lw x0,0(x2)
    step();
    set_id(1'b1, 32'h304, 5'd0, 5'd0, 5'd6, C_RTYPE);     // add x6,x0,x0
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rd_x0_stall: got %0b expected 0", stall_o); end
    step();
    set_id(1'b1, 32'h308, 5'd2, 5'd0, 5'd5, C_LOAD);      // lw x5,0(x2)
    step();
    set_id(1'b1, 32'h30C, 5'd2, 5'd5, 5'd6, C_ITYPE);     // addi x6,x2,imm with rs2 field = 5
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL itype_rs2_stall: got %0b expected 0", stall_o); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h30C) begin errors++;
      $display("FAIL itype_capture: got v=%0b pc=%h expected v=1 pc=0000030c", ex_valid, ex_pc); end
    $display("no_stall: stall_o=%0b ex_pc=%h", stall_o, ex_pc);
  endtask

  task automatic test_store_hazard();
    set_id(1'b1, 32'h400, 5'd2, 5'd0, 5'd5, C_LOAD);      // lw x5,0(x2)
    step();
    set_id(1'b1, 32'h404, 5'd2, 5'd5, 5'd0, C_STORE);     // sw x5,0(x2)
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL store_stall: got %0b expected 1", stall_o); end
    step();
    checks++; if (ex_valid !== 1'b0 || ex_mem_w_en !== 1'b0) begin errors++;
      $display("FAIL store_bubble: got v=%0b mw=%0b expected 0 0", ex_valid, ex_mem_w_en); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_mem_w_en !== 1'b1 || ex_pc !== 32'h404) begin errors++;
      $display("FAIL store_in_ex: got v=%0b mw=%0b pc=%h expected 1 1 00000404", ex_valid, ex_mem_w_en, ex_pc); end
    $display("store_hazard: ex_pc=%h ex_mem_w_en=%0b", ex_pc, ex_mem_w_en);
  endtask

  task automatic test_invalid();
    set_id(1'b0, 32'h500, 5'd1, 5'd2, 5'd9, 5'b11111);
    step();
    checks++; if (ex_valid !== 1'b0 || {ex_rs2_imm_sel, ex_reg_w_en, ex_mem_w_en, ex_mem_alu_sel, ex_branch_detect} !== 5'b0)
      begin errors++; $display("FAIL invalid_bubble: got v=%0b ctrl=%b expected 0 00000", ex_valid,
        {ex_rs2_imm_sel, ex_reg_w_en, ex_mem_w_en, ex_mem_alu_sel, ex_branch_detect}); end
    $display("invalid: ex_valid=%0b", ex_valid);
  endtask

  task automatic test_flush();
    @(negedge clk); rst_n = 1'b0;
    step();
    @(negedge clk); rst_n = 1'b1;
    set_id(1'b1, 32'h600, 5'd2, 5'd0, 5'd5, C_LOAD);      // lw x5,0(x2)
    step();
    set_id(1'b1, 32'h604, 5'd5, 5'd7, 5'd6, C_RTYPE);     // add x6,x5,x7
    ex_flush = 1'b1; #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b expected 0", stall_o); end
    step();
    checks++; if (ex_valid !== 1'b0 || ex_reg_w_en !== 1'b0) begin errors++;
      $display("FAIL flush_bubble: got v=%0b rw=%0b expected 0 0", ex_valid, ex_reg_w_en); end
`ifdef ID_EX_PERF_CNT_EN
    checks++; if (perf_flush_cnt !== 32'd1 || perf_stall_cnt !== 32'd0) begin errors++;
      $display("FAIL flush_perf: got flush=%0d stall=%0d expected 1 0", perf_flush_cnt, perf_stall_cnt); end
`endif
    @(negedge clk); ex_flush = 1'b0;
    $display("flush: ex_valid=%0b stall_o=%0b", ex_valid, stall_o);
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_stall();
    test_store_hazard();
    test_invalid();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
